// File: rtl/wb_stage_multi_pkg.sv
// Shared definitions for the multi-lane write-back stage: stall encoding, lane bus layout
// and width helpers.
package wb_stage_multi_pkg;

  localparam logic Stop   = 1'b1;
  localparam logic NoStop = 1'b0;

  localparam int STALL_W = 6;
  typedef logic [STALL_W-1:0] StallBus;

  localparam int PC_W   = 32;
  localparam int ADDR_W = 5;

  // MEM->WB lane, LSB first: rf_wdata, rf_waddr, rf_we, pc, lo, hi, we_lo, we_hi, valid
  typedef enum logic [3:0] {
    F_WDATA, F_WADDR, F_RFWE, F_PC, F_LO, F_HI, F_WELO, F_WEHI, F_VALID
  } lane_field_e;

  function automatic int lane_off(input lane_field_e f, input int dw);
    case (f)
      F_WDATA: return 0;
      F_WADDR: return dw;
      F_RFWE:  return dw + ADDR_W;
      F_PC:    return dw + ADDR_W + 1;
      F_LO:    return dw + ADDR_W + 1 + PC_W;
      F_HI:    return 2*dw + ADDR_W + 1 + PC_W;
      F_WELO:  return 3*dw + ADDR_W + 1 + PC_W;
      F_WEHI:  return 3*dw + ADDR_W + 2 + PC_W;
      default: return 3*dw + ADDR_W + 3 + PC_W;
    endcase
  endfunction

  function automatic int wb_lane_wd(input int dw);
    return 3*dw + ADDR_W + 4 + PC_W;
  endfunction

  function automatic int rf_lane_wd(input int dw);
    return dw + ADDR_W + 1;
  endfunction

  // trace entry {pc, rf_we, rf_waddr, rf_wdata}
  function automatic int trace_wd(input int dw);
    return PC_W + 1 + ADDR_W + dw;
  endfunction

endpackage

// File: rtl/wb_stage_multi_trace_fifo.sv
// Multi-push, single-pop FIFO feeding the debug trace. Valid push slots are packed in
// slot order; the head pops every cycle the FIFO is non-empty.
module wb_trace_fifo #(
  parameter int W     = 70,
  parameter int DEPTH = 8,
  parameter int NPUSH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NPUSH-1:0]             push_vld,
  input  logic [NPUSH-1:0][W-1:0]      push_data,
  output logic [W-1:0]                 head,
  output logic                         head_vld,
  output logic [$clog2(DEPTH):0]       count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]              mem [DEPTH];
  logic [AW-1:0]             wr_ptr, rd_ptr;
  logic [NPUSH-1:0][AW-1:0]  off;
  logic [AW:0]               npush;
  logic                      pop;

  // slot offsets so that only valid slots consume entries, oldest slot first
  always_comb begin
    npush = '0;
    for (int i = 0; i < NPUSH; i++) begin
      off[i] = npush[AW-1:0];
      npush  = npush + (AW+1)'(push_vld[i]);
    end
  end

  assign pop      = (count != '0);
  assign head_vld = pop;
  assign head     = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst)
      for (int i = 0; i < NPUSH; i++)
        if (push_vld[i]) mem[wr_ptr + off[i]] <= push_data[i];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + npush[AW-1:0];
      rd_ptr <= rd_ptr + AW'(pop);
      count  <= count + npush - (AW+1)'(pop);
    end
  end

  // the stage's stall request keeps free space >= one bundle, so this must hold
  always_ff @(posedge clk) begin
    if (!rst) assert (int'(count) + int'(npush) - int'(pop) <= DEPTH);
  end

endmodule

// File: rtl/wb_stage_multi.sv
// Multi-issue write-back stage: pipeline register, RF/HI/LO write-conflict resolution and
// serialised debug trace. Optional retire counter enabled by WB_RETIRE_CNT_EN.
module wb_stage_multi
  import wb_stage_multi_pkg::*;
#(
  parameter int LANES       = 2,
  parameter int DATA_W      = 32,
  parameter int TRACE_DEPTH = 8
) (
  input  logic                                               clk,
  input  logic                                               rst,
  input  logic                                               flush,
  input  StallBus                                            stall,
  input  logic [LANES*wb_lane_wd(DATA_W)-1:0]                mem_to_wb_bus,
  output logic [LANES*rf_lane_wd(DATA_W)+2+2*DATA_W-1:0]     wb_to_rf_bus,
  output logic                                               wb_stallreq,
  output logic [PC_W-1:0]                                    debug_wb_pc,
  output logic [3:0]                                         debug_wb_rf_wen,
  output logic [ADDR_W-1:0]                                  debug_wb_rf_wnum,
  output logic [DATA_W-1:0]                                  debug_wb_rf_wdata
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [63:0]                                        retire_cnt
`endif
);
  localparam int WB_LANE_WD = wb_lane_wd(DATA_W);
  localparam int RF_LANE_WD = rf_lane_wd(DATA_W);
  localparam int TR_W       = trace_wd(DATA_W);
  localparam int O_WADDR    = lane_off(F_WADDR, DATA_W);
  localparam int O_RFWE     = lane_off(F_RFWE,  DATA_W);
  localparam int O_PC       = lane_off(F_PC,    DATA_W);
  localparam int O_LO       = lane_off(F_LO,    DATA_W);
  localparam int O_HI       = lane_off(F_HI,    DATA_W);
  localparam int O_WELO     = lane_off(F_WELO,  DATA_W);
  localparam int O_WEHI     = lane_off(F_WEHI,  DATA_W);
  localparam int O_VLD      = lane_off(F_VALID, DATA_W);

  logic [LANES-1:0][WB_LANE_WD-1:0] wb_r, in_lanes;
  logic                             fresh;
  logic                             load, bubble, in_any_vld;

  logic [LANES-1:0]                 v, rf_we_raw, we_hi_l, we_lo_l, rf_we_o;
  logic [LANES-1:0][ADDR_W-1:0]     waddr;
  logic [LANES-1:0][DATA_W-1:0]     wdata, hi_l, lo_l;
  logic [LANES-1:0][PC_W-1:0]       pc;

  logic                             we_hi_m, we_lo_m;
  logic [DATA_W-1:0]                hi_m, lo_m;

  logic [LANES-1:0]                 push_vld;
  logic [LANES-1:0][TR_W-1:0]       push_data;
  logic [TR_W-1:0]                  head;
  logic                             head_vld;
  logic [$clog2(TRACE_DEPTH):0]     count;

  wire unused_stall = ^stall[3:0];

  assign in_lanes = mem_to_wb_bus;
  assign load     = (stall[4] == NoStop);
  assign bubble   = (stall[4] == Stop) && (stall[5] == NoStop);

  always_comb begin
    in_any_vld = 1'b0;
    for (int k = 0; k < LANES; k++) in_any_vld |= in_lanes[k][O_VLD];
  end

  always_ff @(posedge clk) begin
    if (rst || flush || bubble) begin
      wb_r  <= '0;
      fresh <= 1'b0;
    end else if (load) begin
      wb_r  <= in_lanes;
      fresh <= in_any_vld;
    end else begin
      fresh <= 1'b0;
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign v[k]         = wb_r[k][O_VLD];
    assign we_hi_l[k]   = wb_r[k][O_WEHI];
    assign we_lo_l[k]   = wb_r[k][O_WELO];
    assign rf_we_raw[k] = wb_r[k][O_RFWE];
    assign waddr[k]     = wb_r[k][O_WADDR +: ADDR_W];
    assign wdata[k]     = wb_r[k][0 +: DATA_W];
    assign hi_l[k]      = wb_r[k][O_HI +: DATA_W];
    assign lo_l[k]      = wb_r[k][O_LO +: DATA_W];
    assign pc[k]        = wb_r[k][O_PC +: PC_W];
    assign push_vld[k]  = fresh & v[k];
    assign push_data[k] = {pc[k], rf_we_raw[k], waddr[k], wdata[k]};
  end

  // a younger lane writing the same nonzero register wins; r0 writes are never masked
  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      rf_we_o[k] = v[k] & rf_we_raw[k];
      for (int j = k + 1; j < LANES; j++)
        if (v[j] && rf_we_raw[j] && waddr[j] == waddr[k] && waddr[k] != '0)
          rf_we_o[k] = 1'b0;
    end
  end

  // ascending scan so the youngest writer of HI and of LO overrides
  always_comb begin
    we_hi_m = 1'b0;
    we_lo_m = 1'b0;
    hi_m    = '0;
    lo_m    = '0;
    for (int k = 0; k < LANES; k++) begin
      if (v[k] && we_hi_l[k]) begin we_hi_m = 1'b1; hi_m = hi_l[k]; end
      if (v[k] && we_lo_l[k]) begin we_lo_m = 1'b1; lo_m = lo_l[k]; end
    end
  end

  always_comb begin
    wb_to_rf_bus = '0;
    for (int k = 0; k < LANES; k++)
      wb_to_rf_bus[k*RF_LANE_WD +: RF_LANE_WD] = {rf_we_o[k], waddr[k], wdata[k]};
    wb_to_rf_bus[LANES*RF_LANE_WD +: 2+2*DATA_W] = {we_hi_m, we_lo_m, hi_m, lo_m};
  end

  wb_trace_fifo #(
    .W     (TR_W),
    .DEPTH (TRACE_DEPTH),
    .NPUSH (LANES)
  ) u_trace_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_vld  (push_vld),
    .push_data (push_data),
    .head      (head),
    .head_vld  (head_vld),
    .count     (count)
  );

  assign wb_stallreq       = (TRACE_DEPTH - int'(count)) < 2*LANES;
  assign debug_wb_pc       = head_vld ? head[DATA_W+ADDR_W+1 +: PC_W] : '0;
  assign debug_wb_rf_wen   = head_vld ? {4{head[DATA_W+ADDR_W]}} : 4'h0;
  assign debug_wb_rf_wnum  = head_vld ? head[DATA_W +: ADDR_W] : '0;
  assign debug_wb_rf_wdata = head_vld ? head[0 +: DATA_W] : '0;

`ifdef WB_RETIRE_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)        retire_cnt <= '0;
    else if (fresh) retire_cnt <= retire_cnt + 64'($countones(v));
  end
`endif

endmodule
